ex_stage: RTL
=============

Name: ex_stage

Overview:
Execute stage of the 5-stage RV32 pipeline. It consumes the ID/EX register outputs, applies forwarding, and computes the ALU result, branch/jump decision and target. It also contains an iterative radix-2 divider for DIV/DIVU/REM/REMU. While a divide runs, the divider stalls the IF/ID/EX registers; results go to the EX/MEM register.

Parameters:
DIV_CYCLES, 32, number of divider iteration cycles (one quotient bit per cycle); must equal the data width.

Ports:
clk_i  in  1  clock
n_rst  in  1  asynchronous active-low reset
flush_i  in  1  abort the in-flight EX operation, including the divider
ex_pc_i  in  32  PC of the instruction in EX
ex_func_i  in  ex_func  operation; enum includes ALU ops, branch compares, EX_JALR, EX_DIV/EX_DIVU/EX_REM/EX_REMU
ex_rs1_sel_i  in  rs1_sel  RS1_VALUE or RS1_PC
ex_rs2_sel_i  in  rs2_sel  RS2_VALUE or RS2_IMM
ex_branch_i  in  1  conditional branch
ex_jmp_i  in  1  unconditional jump (JAL/JALR)
ex_rs1_data_i  in  32  register-file rs1
ex_rs2_data_i  in  32  register-file rs2
ex_immediate_i  in  32  sign-extended immediate
fwd_a_sel_i  in  2  rs1 source: 0 regfile, 1 mem_fwd_data_i, 2 wb_fwd_data_i, 3 regfile
fwd_b_sel_i  in  2  rs2 source, same encoding
mem_fwd_data_i  in  32  EX/MEM result
wb_fwd_data_i  in  32  MEM/WB writeback value
ex_result_o  out  32  ALU or divider result
ex_store_data_o  out  32  forwarded rs2 for stores
ex_branch_taken_o  out  1  redirect PC; also flushes IF/ID and ID/EX
ex_branch_target_o  out  32  redirect target
ex_busy_o  out  1  stall request to the pipeline registers

Behaviour:
- Operand A is PC if RS1_PC, otherwise the forwarded rs1.
- Operand B is the immediate if RS2_IMM, otherwise the forwarded rs2.
- ALU path is combinational, 0-cycle latency. Shift amount is B[4:0]. SLT is signed and SLTU unsigned.
- Branch compares always use forwarded rs1 and rs2.
- Target is ex_pc_i + imm. For EX_JALR the target is (fwd_rs1 + imm) & ~1.
- ex_branch_taken_o = (ex_jmp_i | (ex_branch_i & cmp)) & ~ex_busy_o & ~flush_i.
- For jumps, ex_result_o = ex_pc_i + 4.
- Divider FSM states are IDLE, CALC and DONE. Registers: dividend/quotient shift register (32), remainder (33), divisor (32), 5-bit counter, sign flags.
- IDLE, non-divide op: no action.
- IDLE, divide op, not flush: ex_busy_o=1 combinationally.
  - Absolute values of the operands are latched (signed ops only).
  - Divisor==0: next state DONE with quotient=0xFFFFFFFF and remainder=dividend (raw).
  - Signed 0x80000000 / 0xFFFFFFFF: next state DONE with quotient=0x80000000 and remainder=0.
  - Otherwise: next state CALC with counter=0.
- CALC: ex_busy_o=1. One restoring step per cycle. After DIV_CYCLES steps go to DONE.
- DONE: ex_busy_o=0. ex_result_o is the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU). Remainder takes the sign of the dividend. Next state IDLE.
- Normal divide latency is 34 cycles from EX entry to result (1 IDLE + 32 CALC + 1 DONE). Special cases take 2 cycles.
- Back-to-back divides: the FSM returns to IDLE on the cycle the second divide enters EX, so that divide restarts cleanly.
- flush_i in any state: next state IDLE, ex_busy_o=0, no redirect.
- Reset values: FSM=IDLE, all divider registers 0, ex_busy_o=0, ex_branch_taken_o=0.
  - Remaining outputs are combinational from the inputs; with the ID/EX reset to ALU_NONE/zeros, ex_result_o=0 and ex_store_data_o=0.
- Reset asserted mid-divide: immediately IDLE, busy deasserts asynchronously.

Optional Feature:
EX_DIV_EN
- Defined: divider FSM as above.
- Undefined: no divider logic. Divide ops return 0, ex_busy_o is tied 0, and reset state is unchanged.

Test Plan:
- ADD, rs1=5, RS2_IMM, imm=-7 -> ex_result_o=0xFFFFFFFE same cycle, busy=0.
- BEQ, pc=0x100, imm=0x20, rs1 forwarded via fwd_a_sel=1 with mem_fwd=9, rs2=9 -> taken=1, target=0x120. Same with rs2=8 -> taken=0.
- DIV -20/3 -> busy high for exactly 33 cycles, then result 0xFFFFFFFA. REM of the same operands -> 0xFFFFFFFE.
- DIVU x/0 with x=0x1234 -> result 0xFFFFFFFF after 1 busy cycle. REM 0x80000000/-1 -> 0.
- flush_i at CALC cycle 10 -> busy drops next cycle, FSM IDLE. A following DIVU 100/7 completes with 14 after 33 busy cycles.
- n_rst pulse mid-CALC -> busy=0 immediately. After release, JALR rs1=0x1001, imm=2 -> target 0x1002, result pc+4.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32 pipeline.
//   Forwarding muxes, combinational ALU, branch compare and target generation,
//   and an optional iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
//   Compile-time option: define EX_DIV_EN to build the divider. Without it,
//   divide ops return 0 and o-busy is tied low.
// Ports:
//   clk_i, n_rst         clock, asynchronous active-low reset
//   flush_i              kill the in-flight EX op (divider included)
//   ex_*_i               ID/EX register contents
//   fwd_a/b_sel_i        0/3 regfile, 1 EX/MEM result, 2 MEM/WB value
//   mem/wb_fwd_data_i    forwarded values
//   ex_result_o          ALU, divider or link (pc+4) result
//   ex_store_data_o      forwarded rs2 for stores
//   ex_branch_taken_o    PC redirect, ex_branch_target_o its target
//   ex_busy_o            stall request while a divide is in progress

package ex_pkg;
   typedef enum logic [4:0] {
      ALU_NONE, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB,
      BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU,
      EX_JALR, EX_DIV, EX_DIVU, EX_REM, EX_REMU
   } ex_func;
   typedef enum logic {RS1_VALUE, RS1_PC} rs1_sel;
   typedef enum logic {RS2_VALUE, RS2_IMM} rs2_sel;
endpackage

module ex_stage
   import ex_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk_i,
   input  logic        n_rst,
   input  logic        flush_i,
   input  logic [31:0] ex_pc_i,
   input  ex_func      ex_func_i,
   input  rs1_sel      ex_rs1_sel_i,
   input  rs2_sel      ex_rs2_sel_i,
   input  logic        ex_branch_i,
   input  logic        ex_jmp_i,
   input  logic [31:0] ex_rs1_data_i,
   input  logic [31:0] ex_rs2_data_i,
   input  logic [31:0] ex_immediate_i,
   input  logic [1:0]  fwd_a_sel_i,
   input  logic [1:0]  fwd_b_sel_i,
   input  logic [31:0] mem_fwd_data_i,
   input  logic [31:0] wb_fwd_data_i,
   output logic [31:0] ex_result_o,
   output logic [31:0] ex_store_data_o,
   output logic        ex_branch_taken_o,
   output logic [31:0] ex_branch_target_o,
   output logic        ex_busy_o
);

   logic [31:0] w_rs1, w_rs2, w_op_a, w_op_b, w_alu, w_div_res;
   logic        w_cmp, w_is_div;
   logic        w_unused;

   always_comb begin
      case (fwd_a_sel_i)
         2'd1:    w_rs1 = mem_fwd_data_i;
         2'd2:    w_rs1 = wb_fwd_data_i;
         default: w_rs1 = ex_rs1_data_i;
      endcase
      case (fwd_b_sel_i)
         2'd1:    w_rs2 = mem_fwd_data_i;
         2'd2:    w_rs2 = wb_fwd_data_i;
         default: w_rs2 = ex_rs2_data_i;
      endcase
   end

   assign w_op_a          = (ex_rs1_sel_i == RS1_PC)  ? ex_pc_i        : w_rs1;
   assign w_op_b          = (ex_rs2_sel_i == RS2_IMM) ? ex_immediate_i : w_rs2;
   assign ex_store_data_o = w_rs2;
   assign w_is_div        = (ex_func_i == EX_DIV) || (ex_func_i == EX_DIVU) ||
                            (ex_func_i == EX_REM) || (ex_func_i == EX_REMU);

   always_comb begin
      w_alu = 32'd0;
      case (ex_func_i)
         ALU_ADD:   w_alu = w_op_a + w_op_b;
         ALU_SUB:   w_alu = w_op_a - w_op_b;
         ALU_SLL:   w_alu = w_op_a << w_op_b[4:0];
         ALU_SLT:   w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
         ALU_SLTU:  w_alu = {31'd0, w_op_a < w_op_b};
         ALU_XOR:   w_alu = w_op_a ^ w_op_b;
         ALU_SRL:   w_alu = w_op_a >> w_op_b[4:0];
         ALU_SRA:   w_alu = 32'($signed(w_op_a) >>> w_op_b[4:0]);
         ALU_OR:    w_alu = w_op_a | w_op_b;
         ALU_AND:   w_alu = w_op_a & w_op_b;
         ALU_PASSB: w_alu = w_op_b;
         default:   w_alu = 32'd0;
      endcase
   end

   // Branch compares always look at the forwarded registers, never at PC/imm.
   always_comb begin
      w_cmp = 1'b0;
      case (ex_func_i)
         BR_EQ:   w_cmp = (w_rs1 == w_rs2);
         BR_NE:   w_cmp = (w_rs1 != w_rs2);
         BR_LT:   w_cmp = ($signed(w_rs1) <  $signed(w_rs2));
         BR_GE:   w_cmp = ($signed(w_rs1) >= $signed(w_rs2));
         BR_LTU:  w_cmp = (w_rs1 <  w_rs2);
         BR_GEU:  w_cmp = (w_rs1 >= w_rs2);
         default: w_cmp = 1'b0;
      endcase
   end

   assign ex_branch_target_o = (ex_func_i == EX_JALR) ?
                               ((w_rs1 + ex_immediate_i) & ~32'd1) :
                               (ex_pc_i + ex_immediate_i);
   assign ex_branch_taken_o  = (ex_jmp_i | (ex_branch_i & w_cmp)) & ~ex_busy_o & ~flush_i;
   assign ex_result_o        = ex_jmp_i ? (ex_pc_i + 32'd4) :
                               w_is_div ? w_div_res : w_alu;

`ifdef EX_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_st_t;

   div_st_t     r_st, w_st_nxt;
   logic [31:0] r_q, r_dvsr;
   logic [32:0] r_rem;
   logic [4:0]  r_cnt;
   logic        r_neg_q, r_neg_r;
   logic        w_busy, w_signed, w_ovf, w_dz;
   logic [31:0] w_abs_a, w_abs_b, w_q_fix, w_r_fix;
   logic [32:0] w_rem_sh;
   logic [33:0] w_sub;

   assign w_signed = (ex_func_i == EX_DIV) || (ex_func_i == EX_REM);
   assign w_abs_a  = (w_signed && w_op_a[31]) ? -w_op_a : w_op_a;
   assign w_abs_b  = (w_signed && w_op_b[31]) ? -w_op_b : w_op_b;
   assign w_dz     = (w_op_b == 32'd0);
   assign w_ovf    = w_signed && (w_op_a == 32'h8000_0000) && (w_op_b == 32'hFFFF_FFFF);

   // Restoring step: shift next dividend bit into the partial remainder and
   // subtract if it fits; the extra top bit of w_sub is the borrow.
   assign w_rem_sh = {r_rem[31:0], r_q[31]};
   assign w_sub    = {1'b0, w_rem_sh} - {2'b00, r_dvsr};

   always_comb begin
      w_st_nxt = r_st;
      w_busy   = 1'b0;
      if (flush_i) begin
         w_st_nxt = S_IDLE;
      end else begin
         case (r_st)
            S_IDLE: if (w_is_div) begin
               w_busy   = 1'b1;
               w_st_nxt = (w_dz || w_ovf) ? S_DONE : S_CALC;
            end
            S_CALC: begin
               w_busy = 1'b1;
               if (r_cnt == 5'(DIV_CYCLES - 1)) w_st_nxt = S_DONE;
            end
            S_DONE:  w_st_nxt = S_IDLE;
            default: w_st_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge n_rst) begin
      if (!n_rst) r_st <= S_IDLE;
      else        r_st <= w_st_nxt;
   end

   always_ff @(posedge clk_i or negedge n_rst) begin
      if (!n_rst) begin
         r_q     <= 32'd0;
         r_rem   <= 33'd0;
         r_dvsr  <= 32'd0;
         r_cnt   <= 5'd0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (!flush_i) begin
         if (r_st == S_IDLE && w_is_div) begin
            r_cnt  <= 5'd0;
            r_dvsr <= w_abs_b;
            if (w_dz) begin
               // Raw results: no sign correction applied later.
               r_q     <= 32'hFFFF_FFFF;
               r_rem   <= {1'b0, w_op_a};
               r_neg_q <= 1'b0;
               r_neg_r <= 1'b0;
            end else if (w_ovf) begin
               r_q     <= 32'h8000_0000;
               r_rem   <= 33'd0;
               r_neg_q <= 1'b0;
               r_neg_r <= 1'b0;
            end else begin
               r_q     <= w_abs_a;
               r_rem   <= 33'd0;
               r_neg_q <= w_signed & (w_op_a[31] ^ w_op_b[31]);
               r_neg_r <= w_signed & w_op_a[31];
            end
         end else if (r_st == S_CALC) begin
            r_cnt <= r_cnt + 5'd1;
            if (!w_sub[33]) begin
               r_rem <= w_sub[32:0];
               r_q   <= {r_q[30:0], 1'b1};
            end else begin
               r_rem <= w_rem_sh;
               r_q   <= {r_q[30:0], 1'b0};
            end
         end
      end
   end

   assign w_q_fix   = r_neg_q ? -r_q : r_q;
   assign w_r_fix   = r_neg_r ? -r_rem[31:0] : r_rem[31:0];
   assign w_div_res = (r_st != S_DONE) ? 32'd0 :
                      ((ex_func_i == EX_DIV) || (ex_func_i == EX_DIVU)) ? w_q_fix : w_r_fix;
   // Gated with reset so the stall drops the moment reset is asserted.
   assign ex_busy_o = w_busy & n_rst;
   assign w_unused  = r_rem[32];
`else
   assign w_div_res = 32'd0;
   assign ex_busy_o = 1'b0;
   assign w_unused  = ^{clk_i, n_rst, 32'(DIV_CYCLES)};
`endif

endmodule
